// File: rtl/reg_writeback.sv
// reg_writeback: sequences register-file updates for a request opcode
// through a three-state IDLE/WR1/WR2 FSM with registered write-port outputs.
module reg_writeback #(
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [7:0]        req_operand,
  input  logic [7:0]        pc_i,
  input  logic [7:0]        cacheptr_i,
  input  logic [7:0]        stackptr_i,
  input  logic [7:0]        headptr_i,
  input  logic [7:0]        register_i,
  output logic [ADDR_W-1:0] wa_o,
  output logic              wen_o,
  output logic [7:0]        write_data_o,
  output logic              done_o,
  output logic              err_o
);
  typedef enum logic [1:0] {IDLE, WR1, WR2} state_t;
  localparam logic [3:0] OP_CALL = 4'd9;
  state_t     r_state, w_next;
  logic [3:0] r_op;
  logic [7:0] r_operand;
  logic       w_accept, w_wen, w_err;
  logic [2:0] w_wa;
  logic [7:0] w_data;
  assign req_ready = r_state == IDLE;
  assign w_accept  = req_valid && req_ready;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_accept ? WR1 : IDLE;
      WR1:     w_next = r_op == OP_CALL ? WR2 : IDLE;
      default: w_next = IDLE;
    endcase
  end
  // Slot addresses: PC=0, cacheptr=1, stackptr=2, headptr=3, register=4
  always_comb begin
    w_wen  = 1'b1;
    w_err  = 1'b0;
    w_wa   = 3'd0;
    w_data = pc_i + 8'd1;
    case (req_op)
      4'd0:    w_wen = 1'b0;
      4'd1:    w_data = pc_i + 8'd1;
      4'd2:    w_data = req_operand;
      4'd3:    begin w_wa = 3'd3; w_data = headptr_i + 8'd1; end
      4'd4:    begin w_wa = 3'd3; w_data = headptr_i - 8'd1; end
      4'd5:    begin w_wa = 3'd2; w_data = stackptr_i - 8'd1; end
      4'd6:    begin w_wa = 3'd2; w_data = stackptr_i + 8'd1; end
      4'd7:    begin w_wa = 3'd4; w_data = req_operand; end
      4'd8:    begin w_wa = 3'd1; w_data = req_operand; end
      4'd9:    begin w_wa = 3'd4; w_data = pc_i + 8'd1; end
      default: begin w_wen = 1'b0; w_err = 1'b1; end
    endcase
  end
  // Write port registers; address/data hold whenever no write is issued
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wen_o        <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
      wa_o         <= '0;
      write_data_o <= '0;
      r_op         <= '0;
      r_operand    <= '0;
    end else begin
      wen_o  <= 1'b0;
      done_o <= 1'b0;
      err_o  <= 1'b0;
      if (w_accept) begin
        wen_o     <= w_wen;
        done_o    <= req_op != OP_CALL;
        err_o     <= w_err;
        r_op      <= req_op;
        r_operand <= req_operand;
        if (w_wen) begin
          wa_o         <= ADDR_W'(w_wa);
          write_data_o <= w_data;
        end
      end else if (r_state == WR1 && r_op == OP_CALL) begin
        wen_o        <= 1'b1;
        done_o       <= 1'b1;
        wa_o         <= '0;
        write_data_o <= r_operand;
      end
    end
endmodule
